// File: rtl/sipo_frame_rx_pkg.sv
// sipo_pkg: shared types and constants for the serial frame receiver.
// Optional feature macro: SIPO_PARITY_EN (adds an even-parity bit per frame).
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Level of the serial line when nothing is being sent.
    localparam logic IDLE_LEVEL = 1'b1;

    // Even-parity bit for up to 32 data bits (XOR of all bits).
    function automatic logic even_par(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/sipo_frame_rx_if.sv
// Parallel output port of the frame receiver: word plus valid/ready handshake.
interface sipo_frame_rx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    // Receiver side drives the word and valid.
    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    // Consumer side drives ready.
    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/sipo_frame_rx_out_buf.sv
// sipo_out_buf: one-word valid/ready holding register for received frames.
// A word pushed while the buffer is full and not being drained is dropped
// and raises the sticky overrun flag. A push in the same cycle as a drain
// replaces the word and keeps valid high.
module sipo_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             n_res,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             err_clr,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             pop_s;
    logic             ovr_set_s;

    // Next-state logic for the holding register and the overrun flag.
    always_comb begin
        dout_d    = dout_q;
        valid_d   = valid_q;
        pop_s     = valid_q & dout_ready;
        ovr_set_s = 1'b0;
        if (push) begin
            if (!valid_q || pop_s) begin
                dout_d  = push_data;
                valid_d = 1'b1;
            end else begin
                ovr_set_s = 1'b1;
            end
        end else begin
            if (pop_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
        end
        // A new overrun in the clearing cycle still wins.
        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // Buffer and flag registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!n_res) begin
            dout_q    <= {WIDTH{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign overrun    = overrun_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-to-parallel frame receiver.
// Frame: one start bit (0), WIDTH data bits LSB first, optional even-parity
// bit, one stop bit (1). Good words go to a one-word valid/ready buffer.
// Optional feature macro: SIPO_PARITY_EN (PARITY state and parity_err output).
module sipo_frame_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             n_res,
    input  logic             sd,
    sipo_frame_rx_if.master  out_if,
    output logic             frame_err,
    output logic             overrun,
    input  logic             err_clr,
    output logic             busy
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    // Set once the line has been seen idle; a held-low line after a bad
    // stop bit must not be mistaken for a new start bit.
    logic             armed_q;
    logic             armed_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             ferr_set_s;
    logic             push_s;
`ifdef SIPO_PARITY_EN
    logic             par_bad_q;
    logic             par_bad_d;
    logic             parity_err_q;
    logic             parity_err_d;
    logic             perr_set_s;
`endif

    // Receive FSM: next state, shifter, counter and error events.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        armed_d    = armed_q;
        ferr_set_s = 1'b0;
        push_s     = 1'b0;
`ifdef SIPO_PARITY_EN
        par_bad_d  = par_bad_q;
        perr_set_s = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if ((sd != IDLE_LEVEL) && armed_q) begin
                    state_d = DATA;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (sd == IDLE_LEVEL) begin
                    armed_d = 1'b1;
                end else begin
                    armed_d = armed_q;
                end
            end
            DATA: begin
                shreg_d = {sd, shreg_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end else begin
                    state_d = DATA;
                end
            end
`ifdef SIPO_PARITY_EN
            PARITY: begin
                par_bad_d  = (sd != even_par(32'(shreg_q)));
                perr_set_s = par_bad_d;
                state_d    = STOP;
            end
`endif
            STOP: begin
                state_d = IDLE;
                armed_d = sd;
                if (sd == 1'b1) begin
`ifdef SIPO_PARITY_EN
                    push_s = ~par_bad_q;
`else
                    push_s = 1'b1;
`endif
                end else begin
                    ferr_set_s = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Sticky flags: a set event beats a clear in the same cycle.
        if (ferr_set_s) begin
            frame_err_d = 1'b1;
        end else if (err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end
`ifdef SIPO_PARITY_EN
        if (perr_set_s) begin
            parity_err_d = 1'b1;
        end else if (err_clr) begin
            parity_err_d = 1'b0;
        end else begin
            parity_err_d = parity_err_q;
        end
`endif
    end

    // FSM and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!n_res) begin
            state_q      <= IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            shreg_q      <= {WIDTH{1'b0}};
            armed_q      <= 1'b1;
            frame_err_q  <= 1'b0;
`ifdef SIPO_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            armed_q      <= armed_d;
            frame_err_q  <= frame_err_d;
`ifdef SIPO_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .CLK        (CLK),
        .n_res      (n_res),
        .push       (push_s),
        .push_data  (shreg_q),
        .err_clr    (err_clr),
        .dout_ready (out_if.dout_ready),
        .dout       (out_if.dout),
        .dout_valid (out_if.dout_valid),
        .overrun    (overrun)
    );

    assign frame_err = frame_err_q;
    assign busy      = (state_q != IDLE);
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx (WIDTH=8): directed scenarios plus
// randomized frames, checked every cycle against a frame-level model.
module tb_sipo_frame_rx;

    localparam int W = 8;

    logic CLK = 1'b0;
    logic n_res;
    logic sd;
    logic err_clr;
    logic frame_err;
    logic overrun;
    logic busy;
`ifdef SIPO_PARITY_EN
    logic parity_err;
`endif

    sipo_frame_rx_if #(.WIDTH(W)) bus ();

    sipo_frame_rx #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .n_res     (n_res),
        .sd        (sd),
        .out_if    (bus),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model state: what the consumer should see on the output port.
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovr;
    logic         m_ferr;
    int           rdy_mode;   // 0: ready low, 1: ready high, 2: random
    bit           clr_rand;   // random err_clr pulses

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive line bit, update the model at the edge, compare.
    // is_stop marks the cycle in which the stop bit of 'word' is sampled.
    task automatic cyc(input logic s, input logic clr_in, input bit is_stop,
                       input logic [W-1:0] word, input logic exp_busy);
        logic rdy;
        logic clr;
        logic pop;
        @(negedge CLK);
        if (rdy_mode == 2) rdy = ($urandom_range(0, 1) == 1);
        else               rdy = (rdy_mode == 1);
        clr = clr_in | (clr_rand && ($urandom_range(0, 7) == 0));
        sd = s;
        bus.dout_ready = rdy;
        err_clr = clr;
        @(posedge CLK);
        pop = m_valid && rdy;
        if (clr) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (is_stop && s) begin
            if (!m_valid || pop) begin
                m_dout  = word;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            if (is_stop) m_ferr = 1'b1;
            if (pop)     m_valid = 1'b0;
        end
        #1;
        check("dout",       32'(bus.dout),       32'(m_dout));
        check("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        check("busy",       32'(busy),           32'(exp_busy));
        check("frame_err",  32'(frame_err),      32'(m_ferr));
        check("overrun",    32'(overrun),        32'(m_ovr));
`ifdef SIPO_PARITY_EN
        check("parity_err", 32'(parity_err),     32'd0);
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input logic stop_bit, input int gap);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < W; i++) cyc(word[i], 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef SIPO_PARITY_EN
        cyc(^word, 1'b0, 1'b0, 8'h00, 1'b1);
`endif
        cyc(stop_bit, 1'b0, 1'b1, word, 1'b0);
        idle(gap);
    endtask

    task automatic do_reset(input int n);
        @(negedge CLK);
        n_res = 1'b0;
        sd = 1'b1;
        bus.dout_ready = 1'b0;
        err_clr = 1'b0;
        repeat (n) @(posedge CLK);
        m_dout = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
        #1;
        check("rst_dout",   32'(bus.dout),       32'd0);
        check("rst_valid",  32'(bus.dout_valid), 32'd0);
        check("rst_busy",   32'(busy),           32'd0);
        check("rst_ferr",   32'(frame_err),      32'd0);
        check("rst_ovr",    32'(overrun),        32'd0);
        @(negedge CLK);
        n_res = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w;
        logic         sb;
        int           gap;
        n_res = 1'b0; sd = 1'b1; err_clr = 1'b0; bus.dout_ready = 1'b0;
        rdy_mode = 0; clr_rand = 1'b0;
        m_dout = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;

        // Reset then idle line.
        do_reset(2);
        idle(5);

        // Single frame held until consumed.
        rdy_mode = 0;
        send_frame(8'hA5, 1'b1, 3);
        check("a5_word", 32'(bus.dout), 32'hA5);
        rdy_mode = 1;
        idle(1);
        check("a5_consumed", 32'(bus.dout_valid), 32'd0);

        // Back-to-back frames with ready high.
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hC3, 1'b1, 2);

        // Overrun and its clear.
        rdy_mode = 0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 1);
        check("ovr_word", 32'(bus.dout), 32'h11);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        rdy_mode = 1;
        idle(2);

        // Framing error; held-low line must not retrigger.
        send_frame(8'hFF, 1'b0, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(1);
        send_frame(8'h0F, 1'b1, 2);
        check("ferr_sticky", 32'(frame_err), 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset in the middle of a frame.
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'(i % 2), 1'b0, 1'b0, 8'h00, 1'b1);
        do_reset(1);
        idle(1);
        send_frame(8'h5A, 1'b1, 2);

        // Randomized frames, ready, gaps, stop errors and clears.
        clr_rand = 1'b1;
        for (int f = 0; f < 40; f++) begin
            rdy_mode = int'($urandom_range(0, 2));
            w   = W'($urandom_range(0, 255));
            sb  = ($urandom_range(0, 5) != 0);
            gap = int'($urandom_range(0, 2)) + (sb ? 0 : 1);
            send_frame(w, sb, gap);
        end
        clr_rand = 1'b0;
        rdy_mode = 1;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
